// File: rtl/segway_pkg.sv
// segway_pkg: controller states, default ADC channel numbers and the reading type
package segway_pkg;
  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;
  localparam logic [2:0] CH_LFT_DEF   = 3'd0;
  localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
  localparam logic [2:0] CH_STEER_DEF = 3'd5;
  localparam logic [2:0] CH_BATT_DEF  = 3'd6;
  typedef logic [11:0] reading_t;
  function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction
endpackage

// File: rtl/spi_mnrch.sv
// spi_mnrch: 16-bit SPI master, SCLK = clk / 2^DIV_W, idles high, with a high
// half-period porch before the first falling edge and after the last rising edge.
module spi_mnrch #(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rspns,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  localparam logic [DIV_W-1:0] HALF    = {1'b1, {(DIV_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] PRE_RISE = {1'b0, {(DIV_W-1){1'b1}}};
  logic [DIV_W-1:0] div;
  logic [4:0]       cnt;
  logic [15:0]      tx;
  assign SCLK = SS_n | div[DIV_W-1];
  // div starts at HALF so the frame opens with SCLK high (front porch)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SS_n  <= 1'b1;
      MOSI  <= 1'b0;
      done  <= 1'b0;
      div   <= '0;
      cnt   <= '0;
      tx    <= '0;
      rspns <= '0;
    end else begin
      done <= 1'b0;
      if (wrt) begin
        SS_n <= 1'b0;
        div  <= HALF;
        cnt  <= '0;
        tx   <= cmd;
      end else if (!SS_n) begin
        div <= div + DIV_W'(1);
        if (div == PRE_RISE) begin
          rspns <= {rspns[14:0], MISO};
          cnt   <= cnt + 5'd1;
        end
        if (&div) begin
          if (cnt == 5'd16) begin
            SS_n <= 1'b1;
            done <= 1'b1;
          end else begin
            MOSI <= tx[15];
            tx   <= {tx[14:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: rtl/load_cell_a2d.sv
// load_cell_a2d: round-robin ADC sequencer; each request runs a command frame,
// a one-cycle gap, then a read frame whose low 12 bits update one reading.
module load_cell_a2d
  import segway_pkg::*;
#(
  parameter int         SCLK_DIV_W = 5,
  parameter logic [2:0] CH_LFT     = CH_LFT_DEF,
  parameter logic [2:0] CH_RGHT    = CH_RGHT_DEF,
  parameter logic [2:0] CH_STEER   = CH_STEER_DEF,
  parameter logic [2:0] CH_BATT    = CH_BATT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt
);
  state_t      state, nxt_state;
  logic [1:0]  robin;
  logic [2:0]  ch;
  logic        wrt, done;
  logic [15:0] rspns;
  reading_t    rd;
  assign rd = rspns[11:0];
  always_comb ch = robin == 2'd0 ? CH_LFT : robin == 2'd1 ? CH_RGHT : robin == 2'd2 ? CH_STEER : CH_BATT;
  always_comb begin
    nxt_state = state;
    wrt       = 1'b0;
    case (state)
      IDLE: if (nxt) begin
        wrt       = 1'b1;
        nxt_state = CMD;
      end
      CMD:  if (done) nxt_state = GAP;
      GAP: begin
        wrt       = 1'b1;
        nxt_state = READ;
      end
      READ: if (done) nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      robin     <= 2'd0;
      lft_ld    <= '0;
      rght_ld   <= '0;
      steer_pot <= '0;
      batt      <= '0;
    end else begin
      state <= nxt_state;
      if (state == READ && done) begin
        robin <= robin + 2'd1;
        if (robin == 2'd0) lft_ld <= rd;
        if (robin == 2'd1) rght_ld <= rd;
        if (robin == 2'd2) steer_pot <= rd;
        if (robin == 2'd3) batt <= rd;
      end
    end
  end
  spi_mnrch #(.DIV_W(SCLK_DIV_W)) u_spi (
    .clk   (clk),
    .rst   (rst),
    .wrt   (wrt),
    .cmd   (adc_cmd(ch)),
    .done  (done),
    .rspns (rspns),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );
endmodule

// File: tb/tb_load_cell_a2d.sv
// tb_load_cell_a2d: ADC model plus scoreboard; frame ends are checked against
// queued MOSI words and expected reading sets.
module tb_load_cell_a2d;
  logic        clk = 1'b0, rst = 1'b1, nxt = 1'b0, MISO = 1'b0;
  logic        SS_n, SCLK, MOSI;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  int tests = 0, fails = 0;
  int cyc = 0, rise_cnt = 0, last_rise = 0, per = 0, frames = 0, accepted = 0;
  logic [15:0] adc_val = '0, shreg = '0, mosi_w = '0;
  bit rd_tog = 0, cur_read = 0;
  logic [15:0] exp_mosi[$];
  logic [47:0] exp_res[$];
  logic [11:0] exp_ld[4];
  int rb = 0;
  logic [15:0] wd[4];

  load_cell_a2d dut (
    .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ADC model: CMD frames return junk, READ frames return adc_val
  always @(negedge SS_n) if (!rst) begin
    frames++;
    cur_read = rd_tog;
    rd_tog   = !rd_tog;
    shreg    = cur_read ? adc_val : 16'h5A5A;
    MISO     = shreg[15];
    rise_cnt = 0;
    mosi_w   = '0;
  end
  always @(posedge SCLK) if (!SS_n && !rst) begin
    if (rise_cnt > 0) per = cyc - last_rise;
    last_rise = cyc;
    rise_cnt++;
    mosi_w = {mosi_w[14:0], MOSI};
    shreg  = {shreg[14:0], 1'b0};
    MISO   = shreg[15];
  end
  always @(posedge rst) rd_tog = 0;

  always @(posedge SS_n) if (!rst) begin
    chk("rises", 48'(rise_cnt), 48'd16);
    chk("sclk_per", 48'(per), 48'd32);
    if (exp_mosi.size() == 0) begin
      tests++; fails++;
      $display("FAIL extra_frame: got frame, expected none");
    end else chk("mosi", 48'(mosi_w), 48'(exp_mosi.pop_front()));
    if (cur_read) begin
      repeat (2) @(posedge clk);
      #1;
      if (exp_res.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_result: got result, expected none");
      end else chk("result", {lft_ld, rght_ld, steer_pot, batt}, exp_res.pop_front());
    end
  end

  task automatic wait_ss_rise();
    logic prev = SS_n;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!prev && SS_n) return;
      prev = SS_n;
    end
    tests++; fails++;
    $display("FAIL ss_rise_timeout: got no SS_n rise, expected one");
  endtask

  task automatic pulse_nxt();
    nxt = 1'b1;
    @(posedge clk);
    #1 nxt = 1'b0;
  endtask

  task automatic req(input logic [15:0] val, input bit noisy);
    adc_val = val;
    exp_mosi.push_back(wd[rb]);
    exp_mosi.push_back(wd[rb]);
    exp_ld[rb] = val[11:0];
    exp_res.push_back({exp_ld[0], exp_ld[1], exp_ld[2], exp_ld[3]});
    rb = (rb + 1) % 4;
    accepted++;
    @(posedge clk);
    #1 pulse_nxt();
    if (noisy) begin
      repeat (40) @(posedge clk);
      #1 pulse_nxt();
      wait_ss_rise();
      @(posedge clk);
      #1 pulse_nxt();
      wait_ss_rise();
      pulse_nxt();
    end
    for (int i = 0; i < 3000 && exp_res.size() != 0; i++) @(posedge clk);
    if (exp_res.size() != 0) begin
      tests++; fails++;
      $display("FAIL req_timeout: got %0d pending, expected 0", exp_res.size());
      exp_res.delete();
    end
    repeat (6) @(posedge clk);
    #1 chk("frames", 48'(frames), 48'(2 * accepted));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ss_n", 48'(SS_n), 48'd1);
    chk("rst_outs", {lft_ld, rght_ld, steer_pot, batt}, 48'd0);
    exp_mosi.delete();
    exp_res.delete();
    for (int i = 0; i < 4; i++) exp_ld[i] = '0;
    rb = 0; frames = 0; accepted = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    wd[0] = 16'h0000; wd[1] = 16'h2000; wd[2] = 16'h2800; wd[3] = 16'h3000;
    for (int i = 0; i < 4; i++) exp_ld[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", 48'(SCLK), 48'd1);
    chk("rst_mosi", 48'(MOSI), 48'd0);
    do_reset();
    req(16'hF123, 0);
    do_reset();
    req(16'h0111, 0);
    req(16'h0222, 0);
    req(16'h0333, 0);
    req(16'h0444, 0);
    req(16'h0ABC, 0);
    req(16'h0555, 1);
    req(16'hFFFF, 0);
    // abort the batt conversion mid read frame
    adc_val = 16'h0999;
    exp_mosi.push_back(wd[3]);
    @(posedge clk);
    #1 pulse_nxt();
    wait_ss_rise();
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (!SS_n && rise_cnt == 8) break;
    end
    chk("abort_pt", 48'(rise_cnt), 48'd8);
    do_reset();
    chk("abort_sclk", 48'(SCLK), 48'd1);
    req(16'h0777, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
